seq_detector_param: RTL and testbench

- Parametrised serial pattern-detector FSM; the generalised successor of the chapter's fixed two-input Mealy machines.
- Watches a 1-bit qualified input stream for a compile-time PAT_W-bit pattern, MSB first, and emits a registered match pulse.
- Keeps a saturating match counter.
- Supports overlapping or non-overlapping detection; used as a reusable control-path building block.

---
 rtl/seq_detector_param.sv | 133 +++++++++++++
 tb/tb_seq_detector_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a saturating match count.
// The next-state table is built from the KMP failure function when the design
// is elaborated, so the pattern is never stored at run time.
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   clr         - synchronous clear, present only with SEQ_DET_CLR_EN
//   in_valid    - qualifies in_bit in this cycle
//   in_bit      - serial data bit; the pattern MSB arrives first
//   match       - one-cycle registered pulse when the pattern completes
//   match_count - number of matches since reset, saturating at its maximum
//   state_o     - length of the currently matched prefix
// Optional feature: define SEQ_DET_CLR_EN to add the clr port.
module seq_detector_param #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int                OVERLAP = 1,
  parameter int                COUNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SEQ_DET_CLR_EN
  input  logic                       clr,
`endif
  input  logic                       in_valid,
  input  logic                       in_bit,
  output logic                       match,
  output logic [COUNT_W-1:0]         match_count,
  output logic [$clog2(PAT_W+1)-1:0] state_o
);

  localparam int SW = $clog2(PAT_W + 1);
  localparam int NS = 2 ** SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t              LAST = SW'(PAT_W - 1);
  localparam logic [COUNT_W-1:0]  CMAX = '1;

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W must be in 2..16");
  end
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("seq_detector_param: COUNT_W must be at least 1");
  end

  // Next state from prefix length k after receiving b. The candidate string
  // is the first k pattern bits followed by b (p[0] is the newest bit). The
  // result is the longest suffix of it, shorter than PAT_W, that is also a
  // pattern prefix; on a full match this is the failure value f.
  function automatic int kmp_next(int k, int b);
    logic [16:0] p;
    int          jmax;
    int          res;
    logic        ok;
    logic        full;
    p = '0;
    p[0] = b[0];
    for (int i = 0; i < k; i++) begin
      p[k-i] = PATTERN[PAT_W-1-i];
    end
    full = (k == PAT_W - 1) && (b[0] == PATTERN[0]);
    jmax = (k + 1 < PAT_W) ? k + 1 : PAT_W - 1;
    res = 0;
    for (int j = 1; j <= jmax; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (p[j-1-i] != PATTERN[PAT_W-1-i]) ok = 1'b0;
      end
      if (ok) res = j;
    end
    if (full && OVERLAP == 0) res = 0;
    return res;
  endfunction

  state_t tbl0 [NS];
  state_t tbl1 [NS];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k < PAT_W) begin : g_live
      localparam int N0 = kmp_next(k, 0);
      localparam int N1 = kmp_next(k, 1);
      assign tbl0[k] = SW'(N0);
      assign tbl1[k] = SW'(N1);
    end else begin : g_dead
      assign tbl0[k] = '0;
      assign tbl1[k] = '0;
    end
  end

  state_t             state;
  state_t             state_n;
  logic               match_n;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_n;
  logic               clr_i;

`ifdef SEQ_DET_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      match <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      match <= match_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    match_n = 1'b0;
    cnt_n   = cnt;
    if (clr_i) begin
      state_n = '0;
      cnt_n   = '0;
    end else if (in_valid) begin
      state_n = in_bit ? tbl1[state] : tbl0[state];
      match_n = (state == LAST) && (in_bit == PATTERN[0]);
      if (match_n && cnt != CMAX) cnt_n = cnt + COUNT_W'(1);
    end
  end

  assign match_count = cnt;
  assign state_o     = state;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed vectors for the pattern detector.
// Three instances share stimulus: overlapping, non-overlapping, 2-bit counter.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;

  logic       a_m, b_m, c_m;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic [2:0] a_st, b_st, c_st;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.OVERLAP(1)) dut_a (
    .clk(clk), .rst(rst),
`ifdef SEQ_DET_CLR_EN
    .clr(clr),
`endif
    .in_valid(in_valid), .in_bit(in_bit),
    .match(a_m), .match_count(a_cnt), .state_o(a_st)
  );

  seq_detector_param #(.OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst),
`ifdef SEQ_DET_CLR_EN
    .clr(clr),
`endif
    .in_valid(in_valid), .in_bit(in_bit),
    .match(b_m), .match_count(b_cnt), .state_o(b_st)
  );

  seq_detector_param #(.COUNT_W(2)) dut_c (
    .clk(clk), .rst(rst),
`ifdef SEQ_DET_CLR_EN
    .clr(clr),
`endif
    .in_valid(in_valid), .in_bit(in_bit),
    .match(c_m), .match_count(c_cnt), .state_o(c_st)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic       b;
    logic [2:0] ast;
    logic       am;
    logic [7:0] acnt;
    logic [2:0] bst;
    logic       bm;
    logic [7:0] bcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic b,
                     input int ast, input int am, input int acnt,
                     input int bst, input int bm, input int bcnt);
    vec_t t;
    t.r = r; t.v = v; t.b = b;
    t.ast = 3'(ast); t.am = am[0]; t.acnt = 8'(acnt);
    t.bst = 3'(bst); t.bm = bm[0]; t.bcnt = 8'(bcnt);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    @(negedge clk);
    in_valid = v;
    in_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // reset with valid toggling input
    add(1,1,1, 0,0,0, 0,0,0);
    add(1,1,0, 0,0,0, 0,0,0);
    // single match 1011
    add(0,1,1, 1,0,0, 1,0,0);
    add(0,1,0, 2,0,0, 2,0,0);
    add(0,1,1, 3,0,0, 3,0,0);
    add(0,1,1, 1,1,1, 0,1,1);
    add(0,0,0, 1,0,1, 0,0,1);
    // overlap vs non-overlap: 1011011
    add(1,0,0, 0,0,0, 0,0,0);
    add(0,1,1, 1,0,0, 1,0,0);
    add(0,1,0, 2,0,0, 2,0,0);
    add(0,1,1, 3,0,0, 3,0,0);
    add(0,1,1, 1,1,1, 0,1,1);
    add(0,1,0, 2,0,1, 0,0,1);
    add(0,1,1, 3,0,1, 1,0,1);
    add(0,1,1, 1,1,2, 1,0,1);
    // gaps: 1,0, three idle cycles with in_bit=1, then 1,1
    add(1,0,0, 0,0,0, 0,0,0);
    add(0,1,1, 1,0,0, 1,0,0);
    add(0,1,0, 2,0,0, 2,0,0);
    add(0,0,1, 2,0,0, 2,0,0);
    add(0,0,1, 2,0,0, 2,0,0);
    add(0,0,1, 2,0,0, 2,0,0);
    add(0,1,1, 3,0,0, 3,0,0);
    add(0,1,1, 1,1,1, 0,1,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r;
      in_valid = vecs[i].v;
      in_bit = vecs[i].b;
      @(posedge clk);
      #1;
      check($sformatf("v%0d a_state", i), 32'(a_st), 32'(vecs[i].ast));
      check($sformatf("v%0d a_match", i), 32'(a_m), 32'(vecs[i].am));
      check($sformatf("v%0d a_count", i), 32'(a_cnt), 32'(vecs[i].acnt));
      check($sformatf("v%0d b_state", i), 32'(b_st), 32'(vecs[i].bst));
      check($sformatf("v%0d b_match", i), 32'(b_m), 32'(vecs[i].bm));
      check($sformatf("v%0d b_count", i), 32'(b_cnt), 32'(vecs[i].bcnt));
    end

    // asynchronous reset while the match pulse is high
    do_reset();
    step(1, 1); step(1, 0); step(1, 1); step(1, 1);
    check("pre_rst match", 32'(a_m), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async match", 32'(a_m), 32'd0);
    check("async count", 32'(a_cnt), 32'd0);
    check("async state", 32'(a_st), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // saturation on the 2-bit counter instance
    do_reset();
    step(1, 1); step(1, 0); step(1, 1); step(1, 1);
    check("sat m1 match", 32'(c_m), 32'd1);
    check("sat m1 count", 32'(c_cnt), 32'd1);
    check("sat m1 state", 32'(c_st), 32'd1);
    for (int n = 2; n <= 5; n++) begin
      step(1, 0); step(1, 1); step(1, 1);
      check($sformatf("sat m%0d match", n), 32'(c_m), 32'd1);
      check($sformatf("sat m%0d count", n), 32'(c_cnt), (n > 3) ? 32'd3 : 32'(n));
    end
    check("sat wide count", 32'(a_cnt), 32'd5);

    // reset mid-pattern, with a bit offered during reset
    do_reset();
    step(1, 1); step(1, 0); step(1, 1);
    check("mid state3", 32'(a_st), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(posedge clk);
    #1;
    check("rst wins state", 32'(a_st), 32'd0);
    check("rst wins match", 32'(a_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    step(1, 1);
    check("after rst state", 32'(a_st), 32'd1);
    check("after rst match", 32'(a_m), 32'd0);

`ifdef SEQ_DET_CLR_EN
    do_reset();
    step(1, 1); step(1, 0); step(1, 1); step(1, 1);
    check("clr pre count", 32'(a_cnt), 32'd1);
    step(1, 0); step(1, 1);
    check("clr pre state", 32'(a_st), 32'd3);
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(posedge clk);
    #1;
    check("clr state", 32'(a_st), 32'd0);
    check("clr match", 32'(a_m), 32'd0);
    check("clr count", 32'(a_cnt), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    step(1, 1);
    check("after clr state", 32'(a_st), 32'd1);
    check("after clr match", 32'(a_m), 32'd0);
    check("after clr count", 32'(a_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
